acq_sdram_sched: RTL

ACQ_SDRAM_SCHED -- requirements
Module: acq_sdram_sched

---
 rtl/acq_sdram_sched_if.sv | 35 +++
 rtl/acq_sdram_sched.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/acq_sdram_sched_if.sv
// Handshake bundle between the ADC capture scheduler and its host, sample source and SDRAM write FIFO.
interface acq_sdram_sched_if #(
   parameter int NUM_CH = 8,
   parameter int DATA_W = 16,
   parameter int CNT_W  = 24
);
   logic                     sdram_init_done;
   logic                     start;
   logic                     stop;
   logic [NUM_CH-1:0]        ch_mask;
   logic [CNT_W-1:0]         max_frames;
   logic                     sample_valid;
   logic [NUM_CH*DATA_W-1:0] ch_data;
   logic                     wr_fifo_afull;
   logic                     wr_load;
   logic                     wr_en;
   logic [DATA_W-1:0]        wr_data;
   logic                     busy;
   logic                     done;
   logic                     overrun;
   logic [CNT_W-1:0]         frame_cnt;
   logic [CNT_W-1:0]         word_cnt;

   modport slave (
      input  sdram_init_done, start, stop, ch_mask, max_frames,
             sample_valid, ch_data, wr_fifo_afull,
      output wr_load, wr_en, wr_data, busy, done, overrun, frame_cnt, word_cnt
   );

   modport master (
      output sdram_init_done, start, stop, ch_mask, max_frames,
             sample_valid, ch_data, wr_fifo_afull,
      input  wr_load, wr_en, wr_data, busy, done, overrun, frame_cnt, word_cnt
   );
endinterface

// File: rtl/acq_sdram_sched.sv
// Serialises per-frame ADC channel snapshots into the SDRAM write FIFO, honouring channel mask,
// FIFO back-pressure, frame limits and abort requests.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  IDLE     | after reset, waiting for an accepted start
//  LOAD     | one cycle: wr_load pulse, counters cleared
//  WAIT_SMP | waiting for sample_valid (or stop / SDRAM loss)
//  WRITE    | streaming the remaining enabled channels of a snapshot
//  DONE     | capture finished, done held until the next start
module acq_sdram_sched #(
   parameter int NUM_CH = 8,
   parameter int DATA_W = 16,
   parameter int CNT_W  = 24
) (
   input logic               clk,
   input logic               rst,
   acq_sdram_sched_if.slave  bus
);
   localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [2:0] {IDLE, LOAD, WAIT_SMP, WRITE, DONE} state_t;

   state_t                   state_q, state_d;
   logic [NUM_CH-1:0]        mask_q, mask_d;
   logic [CNT_W-1:0]         max_q, max_d;
   logic [NUM_CH*DATA_W-1:0] snap_q, snap_d;
   logic [PTR_W-1:0]         ptr_q, ptr_d;
   logic                     stop_pend_q, stop_pend_d;
   logic                     last_wr_q, last_wr_d;
   logic                     wr_load_q, wr_load_d;
   logic                     wr_en_q, wr_en_d;
   logic [DATA_W-1:0]        wr_data_q, wr_data_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic                     overrun_q, overrun_d;
   logic [CNT_W-1:0]         frame_cnt_q, frame_cnt_d;
   logic [CNT_W-1:0]         word_cnt_q, word_cnt_d;

   logic                     do_wr;
   logic [PTR_W-1:0]         wr_ptr;
   logic [DATA_W-1:0]        wr_word;
   logic [PTR_W:0]           nxt;
   logic                     halt_req;
   logic                     frame_limit;

   function automatic logic [PTR_W-1:0] first_en(input logic [NUM_CH-1:0] m);
      logic [PTR_W-1:0] r;
      r = '0;
      for (int i = NUM_CH-1; i >= 0; i--)
         if (m[i]) r = PTR_W'(i);
      return r;
   endfunction

   function automatic logic [PTR_W:0] next_en(input logic [NUM_CH-1:0] m, input logic [PTR_W-1:0] p);
      logic [PTR_W:0] r;
      r = '0;
      for (int i = NUM_CH-1; i >= 0; i--)
         if (m[i] && (i > int'(p))) r = {1'b1, PTR_W'(i)};
      return r;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   always_comb begin
      state_d     = state_q;
      mask_d      = mask_q;
      max_d       = max_q;
      snap_d      = snap_q;
      ptr_d       = ptr_q;
      stop_pend_d = stop_pend_q;
      last_wr_d   = 1'b0;
      wr_en_d     = 1'b0;
      wr_data_d   = wr_data_q;
      overrun_d   = overrun_q;
      frame_cnt_d = frame_cnt_q;
      word_cnt_d  = word_cnt_q;
      do_wr       = 1'b0;
      wr_ptr      = ptr_q;
      wr_word     = snap_q[ptr_q*DATA_W +: DATA_W];
      nxt         = '0;
      halt_req    = bus.stop || !bus.sdram_init_done;
      frame_limit = (max_q != '0) &&
                    ((CNT_W+1)'(frame_cnt_q) + (CNT_W+1)'(1) == (CNT_W+1)'(max_q));

      case (state_q)
         IDLE, DONE: begin
            if (bus.start && bus.sdram_init_done && (bus.ch_mask != '0)) begin
               state_d     = LOAD;
               mask_d      = bus.ch_mask;
               max_d       = bus.max_frames;
               frame_cnt_d = '0;
               word_cnt_d  = '0;
               overrun_d   = 1'b0;
               stop_pend_d = 1'b0;
               ptr_d       = '0;
            end
         end
         LOAD: state_d = WAIT_SMP;
         WAIT_SMP: begin
            if (halt_req) begin
               state_d = DONE;
            end else if (bus.sample_valid) begin
               // The cycle showing a frame's last word still counts as busy for the sampler.
               if (last_wr_q) begin
                  overrun_d = 1'b1;
               end else begin
                  snap_d  = bus.ch_data;
                  ptr_d   = first_en(mask_q);
                  state_d = WRITE;
                  if (!bus.wr_fifo_afull) begin
                     do_wr   = 1'b1;
                     wr_ptr  = first_en(mask_q);
                     wr_word = bus.ch_data[first_en(mask_q)*DATA_W +: DATA_W];
                  end
               end
            end
         end
         WRITE: begin
            if (bus.sample_valid) overrun_d = 1'b1;
            if (halt_req) stop_pend_d = 1'b1;
            if (!bus.wr_fifo_afull) do_wr = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (do_wr) begin
         wr_en_d    = 1'b1;
         wr_data_d  = wr_word;
         word_cnt_d = sat_inc(word_cnt_q);
         nxt        = next_en(mask_q, wr_ptr);
         if (nxt[PTR_W]) begin
            ptr_d   = nxt[PTR_W-1:0];
            state_d = WRITE;
         end else begin
            ptr_d       = '0;
            last_wr_d   = 1'b1;
            frame_cnt_d = sat_inc(frame_cnt_q);
            state_d     = (frame_limit || stop_pend_q || halt_req) ? DONE : WAIT_SMP;
         end
      end

      if (state_d == DONE) stop_pend_d = 1'b0;
      wr_load_d = (state_d == LOAD);
      busy_d    = (state_d == LOAD) || (state_d == WAIT_SMP) || (state_d == WRITE);
      done_d    = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         mask_q      <= '0;
         max_q       <= '0;
         snap_q      <= '0;
         ptr_q       <= '0;
         stop_pend_q <= 1'b0;
         last_wr_q   <= 1'b0;
         wr_load_q   <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_data_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         overrun_q   <= 1'b0;
         frame_cnt_q <= '0;
         word_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         max_q       <= max_d;
         snap_q      <= snap_d;
         ptr_q       <= ptr_d;
         stop_pend_q <= stop_pend_d;
         last_wr_q   <= last_wr_d;
         wr_load_q   <= wr_load_d;
         wr_en_q     <= wr_en_d;
         wr_data_q   <= wr_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         overrun_q   <= overrun_d;
         frame_cnt_q <= frame_cnt_d;
         word_cnt_q  <= word_cnt_d;
      end
   end

   assign bus.wr_load   = wr_load_q;
   assign bus.wr_en     = wr_en_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.overrun   = overrun_q;
   assign bus.frame_cnt = frame_cnt_q;
   assign bus.word_cnt  = word_cnt_q;
endmodule
